// File: rtl/midi_pkg.sv
// Shared MIDI constants, rx FSM state encoding and status masks used by the
// serial front end and the parser behind it.
package midi_pkg;

    localparam int MIDI_BAUD       = 31250;
    localparam int MIDI_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam logic [7:0] NOTE_ON  = 8'h90;
    localparam logic [7:0] NOTE_OFF = 8'h80;

endpackage

// File: rtl/midi_uart_rx_if.sv
// Byte stream from the MIDI uart to the parser: data, strobe and line status.
interface midi_uart_rx_if;

    logic [7:0] midi_byte;
    logic       midi_ready;
    logic       frame_err;
    logic       busy;

    modport master (output midi_byte, midi_ready, frame_err, busy);
    modport slave  (input  midi_byte, midi_ready, frame_err, busy);

endinterface

// File: rtl/midi_baud_tick.sv
// Oversample tick divider; restart realigns the phase to a start-bit edge.
module midi_baud_tick #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 receiver: synchronise, oversample, majority-vote each bit and hand
// well-formed bytes to the parser with a single-cycle strobe.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = MIDI_BAUD,
    parameter int OVERSAMPLE = MIDI_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic midi_rx,
    midi_uart_rx_if.master host
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);

    logic      rx_m, rx_s, rx_d;
    logic      fall, tick, restart, maj;
    rx_state_t state, state_nxt;
    logic [SW-1:0] s_cnt, s_cnt_nxt, s_inc;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shift_reg, shift_nxt, byte_q, byte_nxt;
    logic [1:0] samp, samp_nxt;
    logic       ready_q, ready_nxt, ferr_q, ferr_nxt;

    // rx_d only feeds edge detection; every decision uses rx_s
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= midi_rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall    = rx_d & ~rx_s;
    assign restart = (state == RX_IDLE) && fall;

    midi_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_IDLE;
            s_cnt     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            samp      <= '0;
            byte_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_cnt     <= s_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            samp      <= samp_nxt;
            byte_q    <= byte_nxt;
            ready_q   <= ready_nxt;
            ferr_q    <= ferr_nxt;
        end
    end

    // s_inc is the tick number just reached, so samples 7/8/9 straddle mid-bit
    // and the wrap back to 0 lands exactly on the bit boundary.
    assign s_inc = s_cnt + 1'b1;
    assign maj   = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);

    always_comb begin
        state_nxt   = state;
        s_cnt_nxt   = s_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        samp_nxt    = samp;
        byte_nxt    = byte_q;
        ready_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    state_nxt = RX_START;
                    s_cnt_nxt = '0;
                end
            end
            RX_START, RX_DATA, RX_STOP: begin
                if (tick) begin
                    s_cnt_nxt = s_inc;
                    if (s_inc == S_A) samp_nxt[0] = rx_s;
                    if (s_inc == S_B) samp_nxt[1] = rx_s;
                    if (s_inc == S_C) begin
                        case (state)
                            RX_START: if (maj) state_nxt = RX_IDLE;
                            RX_DATA:  shift_nxt = {maj, shift_reg[7:1]};
                            default: begin
                                if (maj) begin
                                    byte_nxt  = shift_reg;
                                    ready_nxt = 1'b1;
                                    state_nxt = RX_IDLE;
                                end else begin
                                    ferr_nxt  = 1'b1;
                                    s_cnt_nxt = '0;
                                    state_nxt = RX_BREAK;
                                end
                            end
                        endcase
                    end
                    if (s_cnt == S_LAST) begin
                        if (state == RX_START) begin
                            state_nxt   = RX_DATA;
                            bit_idx_nxt = '0;
                        end else if (state == RX_DATA) begin
                            if (bit_idx == 3'd7)
                                state_nxt = RX_STOP;
                            else
                                bit_idx_nxt = bit_idx + 1'b1;
                        end
                    end
                end
            end
            RX_BREAK: begin
                // one full bit time of continuous idle before rearming
                if (!rx_s)
                    s_cnt_nxt = '0;
                else if (tick) begin
                    if (s_cnt == S_LAST)
                        state_nxt = RX_IDLE;
                    else
                        s_cnt_nxt = s_inc;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign host.midi_byte  = byte_q;
    assign host.midi_ready = ready_q;
    assign host.frame_err  = ferr_q;
    assign host.busy       = (state != RX_IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx: good bytes, back-to-back, glitch, framing
// error with break, mid-frame reset and +/-3% baud offsets.
module tb_midi_uart_rx;

    // 4 MHz clock keeps the divider at 8 so a bit is 128 clocks.
    localparam int TB_CLK = 4_000_000;
    localparam int DIV    = 8;
    localparam int BIT    = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic midi_rx = 1'b1;

    midi_uart_rx_if bus();

    midi_uart_rx #(
        .CLK_HZ    (TB_CLK),
        .BAUD      (31250),
        .OVERSAMPLE(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .midi_rx(midi_rx),
        .host   (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // strobe monitor, sampled on the falling edge
    int n_rdy = 0, n_ferr = 0, n_dbl = 0, n_both = 0, n_hold = 0;
    logic [7:0] held = 8'h00;
    logic prev_rdy = 1'b0;
    logic [7:0] got_q[$];
    time t_rdy = 0;

    always @(negedge clk) begin
        if (rst) begin
            held     <= 8'h00;
            prev_rdy <= 1'b0;
        end else begin
            if (bus.midi_ready) begin
                n_rdy <= n_rdy + 1;
                got_q.push_back(bus.midi_byte);
                held  <= bus.midi_byte;
                t_rdy <= $time;
                if (prev_rdy) n_dbl <= n_dbl + 1;
            end else if (bus.midi_byte !== held) begin
                n_hold <= n_hold + 1;
            end
            if (bus.frame_err) n_ferr <= n_ferr + 1;
            if (bus.midi_ready && bus.frame_err) n_both <= n_both + 1;
            prev_rdy <= bus.midi_ready;
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int bl, input logic stop);
        midi_rx = 1'b0;
        wclk(bl);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            wclk(bl);
        end
        midi_rx = stop;
        wclk(bl);
    endtask

    function automatic logic [7:0] pop();
        if (got_q.size() == 0) return 8'hxx;
        return got_q.pop_front();
    endfunction

    int base, fbase, lat;
    time t_start;
    logic [7:0] exp_seq [3];

    initial begin
        exp_seq[0] = 8'h90; exp_seq[1] = 8'h3C; exp_seq[2] = 8'h64;
        wclk(5);
        chk("rst_byte",  bus.midi_byte,  8'h00);
        chk("rst_ready", bus.midi_ready, 1'b0);
        chk("rst_ferr",  bus.frame_err,  1'b0);
        chk("rst_busy",  bus.busy,       1'b0);
        rst = 1'b0;
        wclk(BIT);

        // single byte and latency
        t_start = $time;
        send(8'h90, BIT, 1'b1);
        wclk(BIT);
        chk("b1_count", n_rdy, 1);
        chk("b1_byte",  pop(), 8'h90);
        chk("b1_ferr",  n_ferr, 0);
        lat = int'((t_rdy - t_start) / 20);
        chk("b1_latency_window", (lat >= 9 * BIT + BIT / 2 - DIV - 3) && (lat <= 9 * BIT + BIT / 2 + DIV + 3), 1'b1);

        // back-to-back, no idle between frames
        base = n_rdy;
        for (int i = 0; i < 3; i++) send(exp_seq[i], BIT, 1'b1);
        wclk(BIT);
        chk("b2b_count", n_rdy - base, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("b2b_byte%0d", i), pop(), exp_seq[i]);
        chk("b2b_hold", bus.midi_byte, 8'h64);

        // quarter-bit low glitch is a false start
        base = n_rdy;
        fbase = n_ferr;
        midi_rx = 1'b0;
        wclk(BIT / 8);
        chk("glitch_busy", bus.busy, 1'b1);
        wclk(BIT / 8);
        midi_rx = 1'b1;
        wclk(BIT / 2 + 16);
        chk("glitch_idle", bus.busy, 1'b0);
        wclk(BIT);
        chk("glitch_no_rdy",  n_rdy - base, 0);
        chk("glitch_no_ferr", n_ferr - fbase, 0);
        chk("glitch_byte",    bus.midi_byte, 8'h64);

        // framing error, line held low, then recovery
        base = n_rdy;
        fbase = n_ferr;
        send(8'h55, BIT, 1'b0);
        wclk(2 * BIT);
        chk("ferr_break_busy", bus.busy, 1'b1);
        midi_rx = 1'b1;
        wclk(3 * BIT);
        chk("ferr_count",  n_ferr - fbase, 1);
        chk("ferr_no_rdy", n_rdy - base, 0);
        chk("ferr_byte",   bus.midi_byte, 8'h64);
        chk("ferr_idle",   bus.busy, 1'b0);
        send(8'h80, BIT, 1'b1);
        wclk(BIT);
        chk("recov_count", n_rdy - base, 1);
        chk("recov_byte",  pop(), 8'h80);

        // reset during data bit 4 of 0xFF
        base = n_rdy;
        midi_rx = 1'b0;
        wclk(BIT);
        midi_rx = 1'b1;
        wclk(4 * BIT + BIT / 2);
        chk("abort_busy_pre", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_byte",  bus.midi_byte,  8'h00);
        chk("abort_ready", bus.midi_ready, 1'b0);
        chk("abort_ferr",  bus.frame_err,  1'b0);
        chk("abort_busy",  bus.busy,       1'b0);
        wclk(3);
        rst = 1'b0;
        wclk(6 * BIT);
        chk("abort_no_rdy", n_rdy - base, 0);
        send(8'h45, BIT, 1'b1);
        wclk(BIT);
        chk("post_rst_count", n_rdy - base, 1);
        chk("post_rst_byte",  pop(), 8'h45);

        // +3% and -3% transmitter rate
        base = n_rdy;
        send(8'hA5, 124, 1'b1);
        wclk(2 * BIT);
        chk("fast_count", n_rdy - base, 1);
        chk("fast_byte",  pop(), 8'hA5);
        send(8'hA5, 132, 1'b1);
        wclk(2 * BIT);
        chk("slow_count", n_rdy - base, 2);
        chk("slow_byte",  pop(), 8'hA5);

        chk("ready_consecutive", n_dbl, 0);
        chk("ready_and_ferr",    n_both, 0);
        chk("byte_hold",         n_hold, 0);
        chk("ferr_total",        n_ferr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
